// File: rtl/psi_seq_ctrl.sv
// psi_seq_ctrl: folded private-set-intersection controller, one two-pointer compare per cycle
module psi_seq_ctrl #(
  parameter int W = 4,
  parameter int K = 4,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W*K-1:0]         in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W*K-1:0]         o,
  output logic [$clog2(K+1)-1:0] o_count,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   busy
);
  localparam int CW = $clog2(K+1);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] KC = CW'(K);
  localparam logic [PW-1:0] PL = PW'(N-1);
  typedef enum logic [1:0] {LOAD, SCAN, COMMIT, DONE} state_t;
  state_t state;
  logic [K-1:0][W-1:0] r, b, t;
  logic [CW-1:0] cnt, i, j, k;
  logic [PW-1:0] p;
  logic [W-1:0] ri, bj;
  assign ri = r[i[IW-1:0]];
  assign bj = b[j[IW-1:0]];
  assign in_ready = state == LOAD;
  assign o_valid = state == DONE;
  assign busy = state == SCAN || state == COMMIT;
  assign o = r;
  assign o_count = cnt;
  // slots of t above k stay zero, so a committed result is zero-padded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      p <= '0;
      r <= '0;
      b <= '0;
      t <= '0;
      cnt <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          if (p == '0) begin
            r <= in_data;
            cnt <= KC;
            if (N == 1) state <= DONE;
            else p <= PW'(1);
          end else begin
            b <= in_data;
            t <= '0;
            i <= '0;
            j <= '0;
            k <= '0;
            state <= SCAN;
          end
        end
        SCAN: if (i == cnt || j == KC) state <= COMMIT;
          else if (ri == bj) begin
            t[k[IW-1:0]] <= ri;
            i <= i + 1'b1;
            j <= j + 1'b1;
            k <= k + 1'b1;
          end else if (ri < bj) i <= i + 1'b1;
          else j <= j + 1'b1;
        COMMIT: begin
          r <= t;
          cnt <= k;
          if (p == PL) state <= DONE;
          else begin
            p <= p + 1'b1;
            state <= LOAD;
          end
        end
        DONE: if (o_ready) begin
          p <= '0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_psi_seq_ctrl.sv
// tb_psi_seq_ctrl: directed checks of the PSI controller for W=4, K=4, N=8
module tb_psi_seq_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, o_ready = 0;
  logic [15:0] in_data = '0;
  logic [15:0] o;
  logic [2:0] o_count;
  logic in_ready, o_valid, busy;
  int nvec = 0, nerr = 0, acc = 0;
  int bcnt [8];
  logic [15:0] d0, d1, dr;

  psi_seq_ctrl #(.W(4), .K(4), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .o(o), .o_count(o_count), .o_valid(o_valid), .o_ready(o_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // feeds party 0, party 1, then dr for the rest, in_valid held high; stops at DONE
  // or once stop_at beats are in and the DUT is busy
  task automatic run(input int stop_at);
    int cyc;
    logic take;
    cyc = 0;
    acc = 0;
    foreach (bcnt[n]) bcnt[n] = 0;
    in_valid = 1;
    in_data = d0;
    while (!o_valid && cyc < 200 && !(acc == stop_at && busy)) begin
      take = in_ready;
      step;
      cyc++;
      if (take) acc++;
      if (busy) begin
        chk("ready_in_busy", in_ready, 0);
        if (acc > 0) bcnt[acc-1]++;
      end
      in_data = acc == 0 ? d0 : acc == 1 ? d1 : dr;
    end
    in_valid = 0;
    chk("no_timeout", cyc < 200, 1);
  endtask

  task automatic finish_set(input string tag, input logic [15:0] eo, input int ec);
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_o"}, o, eo);
    chk({tag, "_count"}, o_count, ec);
    chk({tag, "_accepts"}, acc, 8);
    o_ready = 1;
    step;
    o_ready = 0;
    chk({tag, "_released"}, o_valid, 0);
    chk({tag, "_ready_again"}, in_ready, 1);
  endtask

  initial begin
    step;
    step;
    chk("rst_o", o, 0);
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1;

    d0 = 16'h8642; d1 = 16'h8642; dr = 16'h8642;
    run(99);
    for (int n = 1; n < 8; n++) chk("full_busy_len", bcnt[n], 6);
    repeat (5) begin
      step;
      chk("hold_valid", o_valid, 1);
      chk("hold_o", o, 16'h8642);
      chk("hold_count", o_count, 4);
    end
    finish_set("full", 16'h8642, 4);

    d0 = 16'h7531; d1 = 16'h6543; dr = 16'h9530;
    run(99);
    finish_set("partial", 16'h0053, 2);

    d0 = 16'h4321; d1 = 16'h8765; dr = 16'h4321;
    run(99);
    for (int n = 2; n < 8; n++) chk("disjoint_busy_len", bcnt[n], 2);
    finish_set("disjoint", 16'h0000, 0);

    d0 = 16'h3322; d1 = 16'h9332; dr = 16'hF332;
    run(99);
    finish_set("dups", 16'h0332, 3);

    d0 = 16'h8642; d1 = 16'h8642; dr = 16'h8642;
    run(4);
    chk("midscan_busy", busy, 1);
    rst_n = 0;
    step;
    rst_n = 1;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_count", o_count, 0);
    chk("mrst_o", o, 0);
    d0 = 16'h7531; d1 = 16'h6543; dr = 16'h9530;
    run(99);
    finish_set("after_rst", 16'h0053, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/psi_seq_ctrl.md
Name: psi_seq_ctrl

Overview:
- Sequential controller for private set intersection over N parties, each holding a K-element ascending array of W-bit values.
- Accepts one party array per handshake beat.
- Keeps a running intersection in a result register and, after each new party, runs one two-pointer compare per cycle against the new array.
- Presents the final intersection and its element count on a valid/ready output port.
- Built as the folded, resource-shared counterpart of the combinational bitonic PSI datapath: one comparator, reused over time.

Parameters:
- W, 4, bit width of each element.
- K, 4, elements per party array; K >= 1.
- N, 8, number of parties; N >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  W*K  one party array; slot s at bits [W*s +: W]; slot 0 is smallest; non-decreasing by slot.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  high only in state LOAD.
- o  output  W*K  intersection, ascending from slot 0; slots >= o_count are 0.
- o_count  output  $clog2(K+1)  number of valid slots in o.
- o_valid  output  1  high only in state DONE.
- o_ready  input  1  consumer accepts o.
- busy  output  1  high in SCAN or COMMIT.

Behaviour:
- Internal state:
  - R (W*K) and cnt: running result and its element count.
  - B (W*K): latched current party array.
  - T (W*K) and k: scan output buffer and its write index.
  - Pointers i, j; party index p, range 0..N-1.
- Reset (rst_n low at an edge): state LOAD, p = 0, and R, cnt, B, T, i, j, k all 0.
  - Outputs after reset: o = 0, o_count = 0, o_valid = 0, busy = 0, in_ready = 1.
  - Reset wins over every other event, including mid-SCAN and mid-DONE.
- LOAD:
  - A beat is accepted when in_valid and in_ready are both high.
  - Party 0 (p = 0): R <= in_data, cnt <= K.
    - If N == 1, go to DONE.
    - Otherwise p <= 1 and stay in LOAD.
  - Party p > 0: B <= in_data; T, i, j, k <= 0; go to SCAN.
- SCAN, one cycle per step:
  - If i == cnt or j == K: go to COMMIT; no compare this cycle.
  - Else if R[i] == B[j]: T[k] <= R[i]; i, j and k each increment.
  - Else if R[i] < B[j]: i increments.
  - Else: j increments.
  - Comparison is unsigned.
  - Equal values pair one-to-one, so duplicates produce multiset intersection.
  - SCAN length is (number of compares) + 1 cycles, at most cnt + K cycles.
  - When cnt == 0, SCAN lasts exactly 1 cycle.
- COMMIT, 1 cycle: R <= T, cnt <= k.
  - If p == N-1, go to DONE.
  - Otherwise p increments and go to LOAD.
- DONE:
  - o = R, o_count = cnt, o_valid = 1; all three stay stable while o_ready is low.
  - On o_valid and o_ready both high: p <= 0, go to LOAD.
  - The next party-0 beat overwrites R.
- o and o_count are driven from R and cnt at all times. They are qualified only by o_valid.
- Inputs seen while in_ready is low are ignored and not consumed.
- Any in_data that is not non-decreasing gives an undefined result, but never a hang: every SCAN terminates within cnt + K + 1 cycles.

Test Plan:
- Full match: all 8 parties send slots 0..3 = {2,4,6,8}.
  - Required: o = 16'h8642, o_count = 4.
  - Each of parties 1..7 gives exactly 5 SCAN cycles plus 1 COMMIT cycle.
- Partial: party0 {1,3,5,7}, party1 {3,4,5,6}, parties 2..7 {0,3,5,9}.
  - Required: o = 16'h0053, o_count = 2.
- Disjoint: party0 {1,2,3,4}, party1 {5,6,7,8}, parties 2..7 {1,2,3,4}.
  - Required: o = 16'h0000, o_count = 0.
  - From party 2 on, each SCAN lasts 1 cycle.
- Duplicates: party0 {2,2,3,3}, party1 {2,3,3,9}, parties 2..7 {2,3,3,15}.
  - Required: o = 16'h0332, o_count = 3.
- Handshake:
  - Hold in_valid high throughout: in_ready is low during SCAN/COMMIT, and no beat is lost or duplicated (8 accepts total).
  - Hold o_ready low for 5 cycles in DONE: o_valid stays 1 and o stays stable.
  - Raise o_ready: o_valid is 0 in the next cycle, in_ready is 1, and a new set is processed correctly.
- Reset mid-operation: assert rst_n low for one cycle during SCAN of party 3.
  - Required next cycle: state LOAD, in_ready = 1, busy = 0, o_valid = 0, o_count = 0.
  - A fresh 8-party run then gives the correct result.
